// File: rtl/alu_writeback_unit.sv
// ALU writeback consumer: owns the NZCV flag register, evaluates each result's
// condition at accept time and queues {result, tag, pass} for the register-file port.
module alu_writeback_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int TAGW  = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N-1:0]    result_i,
  input  logic [3:0]      flags_i,
  input  logic            setflags_i,
  input  logic [3:0]      cond_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N-1:0]    out_result_o,
  output logic [TAGW-1:0] out_tag_o,
  output logic            out_we_o,
  output logic [3:0]      flags_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_flags;

  logic [N-1:0]    r_mem_result [DEPTH];
  logic [TAGW-1:0] r_mem_tag    [DEPTH];
  logic            r_mem_pass   [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_pass;
  logic w_c, w_n, w_v, w_z;

  // in_ready depends on registered count only, so out_ready_i never reaches it.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid_i & ~w_full;
  assign w_pop   = out_ready_i & ~w_empty;

  assign w_c = r_flags[3];
  assign w_n = r_flags[2];
  assign w_v = r_flags[1];
  assign w_z = r_flags[0];

  always_comb begin
    w_pass = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: w_pass = w_z;
      COND_NE: w_pass = ~w_z;
      COND_CS: w_pass = w_c;
      COND_CC: w_pass = ~w_c;
      COND_MI: w_pass = w_n;
      COND_PL: w_pass = ~w_n;
      COND_VS: w_pass = w_v;
      COND_VC: w_pass = ~w_v;
      COND_HI: w_pass = w_c & ~w_z;
      COND_LS: w_pass = ~w_c | w_z;
      COND_GE: w_pass = (w_n == w_v);
      COND_LT: w_pass = (w_n != w_v);
      COND_GT: w_pass = ~w_z & (w_n == w_v);
      COND_LE: w_pass = w_z | (w_n != w_v);
      COND_AL: w_pass = 1'b1;
      COND_NV: w_pass = 1'b0;
      default: w_pass = 1'b0;
    endcase
  end

  // Flags change only on an accepted, passing, flag-setting op.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_flags <= 4'b0000;
    end else if (w_push && w_pass && setflags_i) begin
      r_flags <= flags_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entries are reset so the head reads zero after reset and nothing stale survives.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_mem_result[gi] <= '0;
        r_mem_tag[gi]    <= '0;
        r_mem_pass[gi]   <= 1'b0;
      end else if (w_push && (r_wr_ptr == AW'(gi))) begin
        r_mem_result[gi] <= result_i;
        r_mem_tag[gi]    <= tag_i;
        r_mem_pass[gi]   <= w_pass;
      end
    end
  end

  assign in_ready_o   = ~w_full;
  assign out_valid_o  = ~w_empty;
  assign out_result_o = w_empty ? '0   : r_mem_result[r_rd_ptr];
  assign out_tag_o    = w_empty ? '0   : r_mem_tag[r_rd_ptr];
  assign out_we_o     = w_empty ? 1'b0 : r_mem_pass[r_rd_ptr];
  assign flags_o      = r_flags;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed bench for alu_writeback_unit: condition evaluation, flag update,
// FIFO full/drain, streaming with pointer wrap and asynchronous reset.
module tb_alu_writeback_unit;

  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int TAGW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [N-1:0]    result_i;
  logic [3:0]      flags_i;
  logic            setflags_i;
  logic [3:0]      cond_i;
  logic [TAGW-1:0] tag_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [N-1:0]    out_result_o;
  logic [TAGW-1:0] out_tag_o;
  logic            out_we_o;
  logic [3:0]      flags_o;

  int n_vec = 0;
  int n_err = 0;

  alu_writeback_unit #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .result_i     (result_i),
    .flags_i      (flags_i),
    .setflags_i   (setflags_i),
    .cond_i       (cond_i),
    .tag_i        (tag_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_tag_o    (out_tag_o),
    .out_we_o     (out_we_o),
    .flags_o      (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] res, input logic [3:0] fl,
                       input logic sf, input logic [3:0] cc, input logic [TAGW-1:0] tg);
    in_valid_i = v;
    result_i   = res;
    flags_i    = fl;
    setflags_i = sf;
    cond_i     = cc;
    tag_i      = tg;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_flags", 64'(flags_o), 64'd0);
    chk("rst_out_result", 64'(out_result_o), 64'd0);
    chk("rst_out_tag", 64'(out_tag_o), 64'd0);
    chk("rst_out_we", 64'(out_we_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Basic push, AL, one-cycle latency
    drive(1'b1, 32'h0000_0005, 4'b0000, 1'b1, 4'd14, 4'd3);
    tick();
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_result", 64'(out_result_o), 64'd5);
    chk("t1_tag", 64'(out_tag_o), 64'd3);
    chk("t1_we", 64'(out_we_o), 64'd1);
    chk("t1_flags", 64'(flags_o), 64'd0);
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    out_ready_i = 1'b1;
    tick();
    chk("t1_drained", 64'(out_valid_o), 64'd0);

    // Z set, then EQ passes, NE fails
    drive(1'b1, 32'h21, 4'b0001, 1'b1, 4'd14, 4'd1);
    tick();
    chk("t2_we0", 64'(out_we_o), 64'd1);
    chk("t2_flags", 64'(flags_o), 64'h1);
    drive(1'b1, 32'h22, 4'b0000, 1'b0, 4'd0, 4'd2);
    tick();
    chk("t2_res1", 64'(out_result_o), 64'h22);
    chk("t2_we1", 64'(out_we_o), 64'd1);
    drive(1'b1, 32'h23, 4'b0000, 1'b0, 4'd1, 4'd3);
    tick();
    chk("t2_res2", 64'(out_result_o), 64'h23);
    chk("t2_we2", 64'(out_we_o), 64'd0);
    chk("t2_flags_hold", 64'(flags_o), 64'h1);
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    tick();
    chk("t2_drained", 64'(out_valid_o), 64'd0);

    // Fill to full with the sink stalled; blocked push must not touch flags
    out_ready_i = 1'b0;
    drive(1'b1, 32'h10, 4'b0000, 1'b0, 4'd14, 4'd4);
    tick();
    chk("t3_ready_1", 64'(in_ready_o), 64'd1);
    drive(1'b1, 32'h11, 4'b0000, 1'b0, 4'd14, 4'd5);
    tick();
    chk("t3_full", 64'(in_ready_o), 64'd0);
    drive(1'b1, 32'h12, 4'b1111, 1'b1, 4'd14, 4'd6);
    tick();
    chk("t3_blocked_flags", 64'(flags_o), 64'h1);
    chk("t3_blocked_ready", 64'(in_ready_o), 64'd0);
    chk("t3_head_stable", 64'(out_result_o), 64'h10);
    chk("t3_tag_stable", 64'(out_tag_o), 64'd4);
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    out_ready_i = 1'b1;
    tick();
    chk("t3_ready_back", 64'(in_ready_o), 64'd1);
    chk("t3_head2", 64'(out_result_o), 64'h11);
    tick();
    chk("t3_drained", 64'(out_valid_o), 64'd0);

    // Streaming push+pop every cycle, pointers wrap several times
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, N'(i), 4'b0000, 1'b0, 4'd14, TAGW'(i));
      tick();
      chk($sformatf("t4_res%0d", i), 64'(out_result_o), 64'(i));
      chk($sformatf("t4_ready%0d", i), 64'(in_ready_o), 64'd1);
    end
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    tick();
    chk("t4_drained", 64'(out_valid_o), 64'd0);

    // C=1 N=1 V=1 Z=0 -> HI, GE, GT pass; NV fails
    drive(1'b1, 32'h30, 4'b1110, 1'b1, 4'd14, 4'd7);
    tick();
    chk("t5_flags", 64'(flags_o), 64'he);
    chk("t5_we_al", 64'(out_we_o), 64'd1);
    drive(1'b1, 32'h31, 4'b0000, 1'b0, 4'd8, 4'd8);
    tick();
    chk("t5_we_hi", 64'(out_we_o), 64'd1);
    drive(1'b1, 32'h32, 4'b0000, 1'b0, 4'd10, 4'd9);
    tick();
    chk("t5_we_ge", 64'(out_we_o), 64'd1);
    drive(1'b1, 32'h33, 4'b0000, 1'b0, 4'd12, 4'd10);
    tick();
    chk("t5_we_gt", 64'(out_we_o), 64'd1);
    drive(1'b1, 32'h34, 4'b0000, 1'b1, 4'd15, 4'd11);
    tick();
    chk("t5_we_nv", 64'(out_we_o), 64'd0);
    chk("t5_nv_flags", 64'(flags_o), 64'he);
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    tick();
    chk("t5_drained", 64'(out_valid_o), 64'd0);

    // Asynchronous reset with an entry queued
    out_ready_i = 1'b0;
    drive(1'b1, 32'h40, 4'b0000, 1'b0, 4'd14, 4'd12);
    tick();
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0, '0);
    chk("t6_queued", 64'(out_valid_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid_o), 64'd0);
    chk("t6_async_flags", 64'(flags_o), 64'd0);
    #2;
    rst_n_i = 1'b1;
    tick();
    chk("t6_ready", 64'(in_ready_o), 64'd1);
    chk("t6_no_stale", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b1;
    tick();
    chk("t6_still_empty", 64'(out_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
- Consumer end of the ALU result/flag interface. Accepts one ALU result per handshake, together with its 4-bit flag vector, a condition code and a destination tag.
- Holds the architectural NZCV flag register and evaluates the condition against it. Optionally updates the flags.
- Queues the result in a small FIFO for the register-file write port, using a valid/ready handshake on both sides.

Parameters:
- N, 32, data width of result_i / out_result_o.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- TAGW, 4, width of destination tag.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous reset, active-low.
- in_valid_i  input  1  upstream holds valid result.
- in_ready_o  output  1  unit can accept.
- result_i  input  N  ALU result.
- flags_i  input  4  ALU flags: [3]=C, [2]=N, [1]=V, [0]=Z.
- setflags_i  input  1  update architectural flags if condition passes.
- cond_i  input  4  condition code (encoding below).
- tag_i  input  TAGW  destination register tag.
- out_valid_o  output  1  FIFO head valid.
- out_ready_i  input  1  write port accepts head.
- out_result_o  output  N  head result.
- out_tag_o  output  TAGW  head tag.
- out_we_o  output  1  head condition passed (write enable).
- flags_o  output  4  architectural flags, same bit order as flags_i.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - FIFO empty; pointers and count = 0.
  - flags_o = 4'b0000.
  - out_valid_o = 0, out_result_o = 0, out_tag_o = 0, out_we_o = 0.
  - in_ready_o = 1 once reset deasserts.
  - Reset mid-transfer discards all queued entries.
- Accept: a push occurs when in_valid_i & in_ready_o at a rising edge.
  - in_ready_o = !full, driven from registered state only; no combinational path from out_ready_i.
- Condition evaluation is combinational at accept time, against flags_o (the current architectural flags, not flags_i):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Pass = result of the evaluation above.
- Flag update on push:
  - If pass & setflags_i: flags_o <= flags_i at the same edge.
  - Otherwise flags_o is held.
  - Back-to-back pushes are therefore evaluated in order; op k sees the flags written by op k-1.
- FIFO entry stores {result_i, tag_i, pass}.
  - Entries with pass=0 are still queued, so ordering is preserved, and are emitted with out_we_o=0.
- Pop: occurs when out_valid_o & out_ready_i at a rising edge; head advances.
- Latency: a push into an empty FIFO gives out_valid_o=1 on the next cycle. There is no bypass of the registered head.
- out_result_o, out_tag_o and out_we_o hold stable while out_valid_o & !out_ready_i.
- Pointers wrap modulo DEPTH. Count goes 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Legal only when not full, since in_ready_o=0 when full.
  - Pop while full raises in_ready_o on the following cycle.
- Push when full is impossible by handshake. in_valid_i while !in_ready_o must not alter state or flags.
- out_ready_i while empty: no effect.
- Flags are written only at accept time; pop never changes flags_o.

Test Plan:
- Reset, then push result=0x0000_0005, flags=4'b0000, cond=14 (AL), setflags=1, tag=3 -> next cycle out_valid_o=1, out_result_o=5, out_tag_o=3, out_we_o=1, flags_o=0000.
- Push flags=4'b0001 (Z), cond=AL, setflags=1; next cycle push cond=0 (EQ), then cond=1 (NE) -> out_we_o sequence 1,1,0; flags_o=0001 after the first push.
- Hold out_ready_i=0 and push twice (DEPTH=2) -> in_ready_o=0 after the 2nd accept. Third in_valid_i is ignored; flags_o is unchanged even with setflags=1. Raise out_ready_i -> in_ready_o=1 the next cycle, entries drain in order.
- Steady stream with in_valid_i=out_ready_i=1 for 8 cycles, results 1..8 -> out_result_o 1..8 in order, one per cycle, pointer wrap exercised, count never exceeds 1.
- Push flags C=1,Z=0,N=1,V=1 with setflags=1, cond=AL; then cond=8 (HI), 10 (GE), 12 (GT), 15 (NV) -> out_we_o = 1,1,1,0.
- Fill 1 entry, assert rst_n_i low mid-cycle -> out_valid_o=0 and flags_o=0 immediately (async). After release, in_ready_o=1 and no stale entry is emitted.
